mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU on the operand pair read from the register file (`RSdata_o`/`RTdata_o`).
- Supports MTHI/MTLO writes.
- Presents HI/LO for MFHI/MFLO, which the datapath muxes onto the register file write-data path (`RDdata_i`).
- Sits beside the ALU, between register-file read and write-back; the pipeline stalls on `busy_o`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  launch an operation; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data_i`  in  WIDTH  operand A (multiplicand/dividend); also MTHI/MTLO data.
- `rt_data_i`  in  WIDTH  operand B (multiplier/divisor).
- `hi_we_i`  in  1  MTHI: HI <= `rs_data_i`.
- `lo_we_i`  in  1  MTLO: LO <= `rs_data_i`.
- `busy_o`  out  1  operation in flight; the pipeline must stall on MFHI/MFLO/MULT/DIV/MTHI/MTLO.
- `done_o`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi_o`  out  WIDTH  HI register.
- `lo_o`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start_i`=1: latch `op_i`. Store |A| and |B| for signed ops, raw values for unsigned. Record the result signs. Clear the partial result, set count=0, go to CALC.
  - `start_i`=0: perform the `hi_we_i`/`lo_we_i` writes. Both may be asserted in the same cycle.
- CALC: one iteration per cycle; count 0..31; leave on count==31 to FIX.
  - Multiply: shift-add over a 64-bit accumulator {P_hi, multiplier}; add the multiplicand when the LSB is 1, then shift right.
  - Divide: restoring; shift {remainder, quotient} left 1, subtract divisor from the remainder; keep the subtraction if non-negative and set quotient LSB=1.
- FIX: apply signs, write HI/LO, pulse `done_o`, return to IDLE.
  - MULT: negate the 64-bit product when signA^signB.
  - DIV: quotient sign = signA^signB; remainder sign = signA.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (B==0), any op: LO = 0xFFFFFFFF, HI = A unmodified. Still takes the full latency; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap, no trap).
- Arithmetic widths:
  - Multiply accumulator: 65 bits internally, to hold the carry.
  - Divide remainder path: 33 bits.
  - Negation: two's complement at the full width.

## Timing
- Reset values: state=IDLE, `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, count=0.
- Start accepted at edge E0; `busy_o`=1 from after E0 until after E33.
- E1..E32: CALC iterations.
- E33: FIX.
  - HI/LO update at E33.
  - `done_o`=1 for exactly the cycle after E33, in which `busy_o`=0.
- Result-to-result latency 33 cycles.
- A new start may be sampled in the same cycle `done_o` is high (back-to-back issue).
- `start_i` while busy: ignored; no queueing.
- `hi_we_i`/`lo_we_i` while busy: ignored.
- `start_i` together with `hi_we_i`/`lo_we_i` in IDLE: start wins, writes dropped.
- HI/LO are unchanged throughout CALC; the architectural values are visible until FIX.
- Reset asserted mid-operation: next edge returns to IDLE with all registers at their reset values. `done_o` does not fire for the aborted op.
- Operands are sampled only at E0; later changes on `rs_data_i`/`rt_data_i` have no effect.

## Structure
- Package `mdu_pkg`:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`
  - state encoding `ST_IDLE`, `ST_CALC`, `ST_FIX`
  - `MDU_ITERS` = 32
- Sub-module `mdu_step`: purely combinational single-iteration datapath (add-shift or subtract-shift selected by op). The FSM, counter, sign logic and HI/LO registers live in `mul_div_unit`.

## Test plan
- MULT 7 x 0xFFFFFFFD (-3) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; `done_o` exactly 33 cycles after the start edge.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; same op with MULT -> HI=0, LO=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT 5x6, re-pulse `start_i` with DIVU at cycle 10 and `hi_we_i` at cycle 12 -> both ignored; HI=0, LO=30 at `done_o`.
  - A start issued in the `done_o` cycle completes 33 cycles later.
- Reset low at cycle 15 of a DIV -> `busy_o`=0, HI=LO=0, no `done_o`; a following DIVU 100/7 -> LO=14, HI=2.
- IDLE: `hi_we_i`=1 with `rs_data_i`=0x1234 -> `hi_o`=0x1234 next cycle, LO unchanged.
  - `lo_we_i` and `hi_we_i` together -> both written.
  - `start_i` with `lo_we_i` -> LO write dropped.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  localparam int unsigned MDU_ITERS = 32;

  function automatic logic op_is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide on the {hi, lo} accumulator.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_diff;

  always_comb begin
    // The extra top bit of mul_sum carries out of the partial-product add.
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    div_diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};
    if (is_div_i) begin
      if (!div_diff[WIDTH]) begin
        acc_o = {div_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; works on magnitudes, fixes signs at end.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic               div_q, div_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               sign_a_q, sign_a_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  mdu_op_e            op_in;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quot, rem;

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i (div_q),
    .operand_i(opnd_q),
    .acc_i    (acc_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_d      = neg_q;
    sign_a_d   = sign_a_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    op_in = mdu_op_e'(op_i);
    a_neg = op_is_signed(op_in) & rs_data_i[WIDTH-1];
    b_neg = op_is_signed(op_in) & rt_data_i[WIDTH-1];
    a_mag = a_neg ? -rs_data_i : rs_data_i;
    b_mag = b_neg ? -rt_data_i : rt_data_i;

    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_CALC;
          busy_d     = 1'b1;
          count_d    = '0;
          div_d      = op_is_div(op_in);
          neg_d      = a_neg ^ b_neg;
          sign_a_d   = a_neg;
          div_zero_d = (rt_data_i == '0);
          // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
          if (op_is_div(op_in)) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end else begin
          if (hi_we_i) hi_d = rs_data_i;
          if (lo_we_i) lo_d = rs_data_i;
        end
      end
      ST_CALC: begin
        acc_d   = acc_step;
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          // With a zero divisor the remainder path returns the dividend unchanged.
          hi_d = rem;
          lo_d = div_zero_q ? '1 : quot;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      div_q      <= 1'b0;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_q      <= neg_d;
      sign_a_q   <= sign_a_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  mul_div_unit #(
    .WIDTH(32)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i),
    .hi_we_i  (hi_we_i),
    .lo_we_i  (lo_we_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned up;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        sq = sa * sb;
        r  = sq;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        r  = up;
      end
      2'b10: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Issues at the current negedge and returns at the negedge where done_o is high,
  // so consecutive calls exercise back-to-back issue.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_lo_we);
    logic [63:0] r;
    int          e;
    bit          seen;
    r         = ref_model(op, a, b);
    op_i      = op;
    rs_data_i = a;
    rt_data_i = b;
    start_i   = 1'b1;
    hi_we_i   = 1'b0;
    lo_we_i   = with_lo_we;
    tick();
    start_i = 1'b0;
    lo_we_i = 1'b0;
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("hilo_hold_start", {hi_o, lo_o}, {m_hi, m_lo});
    e    = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      rs_data_i = $urandom;
      rt_data_i = $urandom;
      op_i      = 2'($urandom);
      start_i   = disturb ? (e == 10) : 1'($urandom_range(0, 1));
      if (disturb && e == 10) op_i = MDU_DIVU;
      hi_we_i   = disturb ? (e == 12) : 1'($urandom_range(0, 1));
      lo_we_i   = disturb ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      e++;
      if (e == 16) begin
        check("busy_mid", 64'(busy_o), 64'd1);
        check("hilo_hold_mid", {hi_o, lo_o}, {m_hi, m_lo});
      end
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(e), 64'(MDU_ITERS + 1));
    check("busy_at_done", 64'(busy_o), 64'd0);
    check("result", {hi_o, lo_o}, r);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  initial begin
    bit any_done;
    rst_i     = 1'b0;
    start_i   = 1'b0;
    hi_we_i   = 1'b0;
    lo_we_i   = 1'b0;
    op_i      = 2'b00;
    rs_data_i = '0;
    rt_data_i = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst_i = 1'b1;
    tick();

    run_op(MDU_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(MDU_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    run_op(MDU_MULT, 32'd5, 32'd6, 1'b1, 1'b0);
    run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    tick();
    check("done_one_cycle", 64'(done_o), 64'd0);

    // Abort a DIV mid-flight.
    op_i      = MDU_DIV;
    rs_data_i = 32'd1000;
    rt_data_i = 32'd3;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_hilo", {hi_o, lo_o}, 64'd0);
    m_hi     = '0;
    m_lo     = '0;
    any_done = 1'b0;
    repeat (40) begin
      tick();
      if (done_o) any_done = 1'b1;
    end
    check("abort_no_done", 64'(any_done), 64'd0);
    run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    tick();

    // Idle HI/LO writes.
    rs_data_i = 32'h1234;
    hi_we_i   = 1'b1;
    tick();
    hi_we_i = 1'b0;
    m_hi    = 32'h1234;
    check("mthi", {hi_o, lo_o}, {m_hi, m_lo});
    rs_data_i = 32'hABCD_0042;
    hi_we_i   = 1'b1;
    lo_we_i   = 1'b1;
    tick();
    hi_we_i = 1'b0;
    lo_we_i = 1'b0;
    m_hi    = 32'hABCD_0042;
    m_lo    = 32'hABCD_0042;
    check("mthi_mtlo", {hi_o, lo_o}, {m_hi, m_lo});
    run_op(MDU_MULTU, 32'd3, 32'd4, 1'b0, 1'b1);
    tick();

    repeat (40) begin
      run_op(2'($urandom), pick(), pick(), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
